// File: rtl/mdio_arbiter_pkg.sv
// Shared constants, state type and frame builder for the MDIO request arbiter.
// The frame is the Clause-22 32-bit word handed to the MDIO master as t_data.
package mdio_arbiter_pkg;

  localparam int PHY_W   = 5;
  localparam int REG_W   = 5;
  localparam int DATA_W  = 16;
  localparam int FRAME_W = 32;

  localparam logic [1:0] ST    = 2'b01;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] TA_WR = 2'b10;
  localparam logic [1:0] TA_RD = 2'b00;

  localparam int ST_LSB   = 30;
  localparam int OP_LSB   = 28;
  localparam int PHY_LSB  = 23;
  localparam int REG_LSB  = 18;
  localparam int TA_LSB   = 16;
  localparam int DATA_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic              wr,
    input logic [PHY_W-1:0]  phy,
    input logic [REG_W-1:0]  regad,
    input logic [DATA_W-1:0] wdata
  );
    logic [FRAME_W-1:0] f;
    f = '0;
    f[ST_LSB +: 2]        = ST;
    f[OP_LSB +: 2]        = wr ? OP_WR : OP_RD;
    f[PHY_LSB +: PHY_W]   = phy;
    f[REG_LSB +: REG_W]   = regad;
    f[TA_LSB +: 2]        = wr ? TA_WR : TA_RD;
    f[DATA_LSB +: DATA_W] = wr ? wdata : '0;
    return f;
  endfunction

endpackage

// File: rtl/mdio_arbiter_if.sv
// Bundle of requester and MDIO-master signals around the arbiter.
// master: the arbiter's view; slave: requesters plus the MDIO master engine.
interface mdio_arbiter_if
  import mdio_arbiter_pkg::*;
#(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_wr;
  logic [PHY_W*NREQ-1:0]  req_phy;
  logic [REG_W*NREQ-1:0]  req_reg;
  logic [DATA_W*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rdata;
  logic                   err;
  logic                   busy;
  logic                   mst_start;
  logic [FRAME_W-1:0]     mst_t_data;
  logic [DATA_W-1:0]      mst_rd_data;
  logic                   mst_data_rdy;

  modport master (
    input  req, req_wr, req_phy, req_reg, req_wdata, mst_rd_data, mst_data_rdy,
    output ack, rdata, err, busy, mst_start, mst_t_data
  );

  modport slave (
    output req, req_wr, req_phy, req_reg, req_wdata, mst_rd_data, mst_data_rdy,
    input  ack, rdata, err, busy, mst_start, mst_t_data
  );
endinterface

// File: rtl/mdio_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from
// the slot after last_grant, wrapping modulo NREQ. Output is one-hot or zero.
module rr_arbiter #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [NREQ-1:0]  grant_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDX_W'((int'(last_grant_i) + k) % NREQ);
      if (req_i[idx] && !found) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mdio_arbiter.sv
// Shares one MDIO master between NREQ requesters: round-robin grant, frame
// build, start pulse, completion tracking (fixed write length / read with timeout).
module mdio_arbiter
  import mdio_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int WR_CYCLES  = 64,
  parameter int RD_TIMEOUT = 256
) (
  input logic            clk,
  input logic            reset,
  mdio_arbiter_if.master bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic               wr_q, wr_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [NREQ-1:0]    rr_grant;
  logic               win_wr;
  logic [PHY_W-1:0]   win_phy;
  logic [REG_W-1:0]   win_reg;
  logic [DATA_W-1:0]  win_wdata;
  logic [IDX_W-1:0]   grant_idx;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i        (bus.req),
    .last_grant_i (last_q),
    .grant_o      (rr_grant)
  );

  // Requester field mux driven by the one-hot winner.
  always_comb begin
    win_wr    = 1'b0;
    win_phy   = '0;
    win_reg   = '0;
    win_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rr_grant[i]) begin
        win_wr    = bus.req_wr[i];
        win_phy   = bus.req_phy[PHY_W*i +: PHY_W];
        win_reg   = bus.req_reg[REG_W*i +: REG_W];
        win_wdata = bus.req_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) grant_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          grant_d = rr_grant;
          wr_d    = win_wr;
          frame_d = build_frame(win_wr, win_phy, win_reg, win_wdata);
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (wr_q) begin
          if (cnt_q == CNT_W'(WR_CYCLES - 1)) begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = S_DONE;
          end
        end else if (bus.mst_data_rdy) begin
          // Data ready beats a coincident timeout.
          rdata_d = bus.mst_rd_data;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
          rdata_d = 16'hFFFF;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_d  = grant_idx;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= IDX_W'(NREQ - 1);
      grant_q <= '0;
      wr_q    <= 1'b0;
      frame_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.ack        = (state_q == S_DONE) ? grant_q : '0;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.mst_start  = (state_q == S_LAUNCH);
  assign bus.mst_t_data = frame_q;
  assign bus.rdata      = rdata_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Self-checking bench for mdio_arbiter: directed table, hand-written corner
// sequences, then random transactions checked against a behavioural model.
module tb_mdio_arbiter;

  localparam int NREQ       = 4;
  localparam int WR_CYCLES  = 64;
  localparam int RD_TIMEOUT = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdio_arbiter_if #(.NREQ(NREQ)) bus ();

  mdio_arbiter #(
    .NREQ       (NREQ),
    .WR_CYCLES  (WR_CYCLES),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int model_last = NREQ - 1;

  typedef struct {
    logic [3:0]  rq;
    logic [3:0]  wr;
    logic [19:0] phy;
    logic [19:0] rg;
    logic [63:0] wd;
    int          rdy_d;
    logic [15:0] rdy_dat;
    int          exp_g;
    logic [31:0] exp_frame;
    int          exp_cyc;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [3:0] rq, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (rq[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_frame(input logic wr, input logic [4:0] p,
                                              input logic [4:0] r, input logic [15:0] d);
    return {2'b01, (wr ? 2'b01 : 2'b10), p, r, (wr ? 2'b10 : 2'b00), (wr ? d : 16'h0000)};
  endfunction

  function automatic int model_cyc(input logic wr, input int rdy_d);
    if (wr) return WR_CYCLES + 2;
    if (rdy_d >= 1 && rdy_d + 1 <= RD_TIMEOUT + 1) return rdy_d + 2;
    return RD_TIMEOUT + 2;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    bus.mst_data_rdy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_last = NREQ - 1;
  endtask

  // Called at a negedge with the DUT idle; that period is cycle 0.
  task automatic run_txn(input logic [3:0] rq, input logic [3:0] wr,
                         input logic [19:0] phy, input logic [19:0] rg, input logic [63:0] wd,
                         input int rdy_d, input logic [15:0] rdy_dat, input int drop_at,
                         input int exp_g, input logic [31:0] exp_frame, input int exp_cyc,
                         input logic chk_rd, input logic [15:0] exp_rdata, input logic exp_err);
    int ack_cyc = -1;
    int starts = 0;
    int frame_bad = 0;
    logic start1 = 1'b0;
    logic [3:0] ack_val = '0;
    logic [15:0] rd_val = '0;
    logic err_val = 1'b0;
    bus.req = rq;
    bus.req_wr = wr;
    bus.req_phy = phy;
    bus.req_reg = rg;
    bus.req_wdata = wd;
    bus.mst_data_rdy = 1'b0;
    for (int c = 1; c <= RD_TIMEOUT + 10 && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (drop_at == c) bus.req = '0;
      if (bus.mst_start) starts++;
      if (c == 1) start1 = bus.mst_start;
      if (bus.busy && bus.mst_t_data !== exp_frame) frame_bad++;
      if (bus.ack !== '0) begin
        ack_cyc = c;
        ack_val = bus.ack;
        rd_val = bus.rdata;
        err_val = bus.err;
      end
      bus.mst_data_rdy = (rdy_d > 0 && c == rdy_d + 1);
      bus.mst_rd_data = bus.mst_data_rdy ? rdy_dat : 16'($urandom);
    end
    chk("start_at_1", start1, 1'b1);
    chk("start_count", starts, 1);
    chk("frame", frame_bad, 0);
    chk("ack_cycle", ack_cyc, exp_cyc);
    chk("ack_vec", ack_val, 4'b0001 << exp_g);
    if (chk_rd) begin
      chk("rdata", rd_val, exp_rdata);
      chk("err", err_val, exp_err);
    end
    bus.req = '0;
    bus.mst_data_rdy = 1'b0;
    @(negedge clk);
    chk("idle_after_ack", {bus.busy, bus.ack}, 5'b0);
    if (chk_rd) chk("rdata_hold", {bus.err, bus.rdata}, {exp_err, exp_rdata});
    model_last = exp_g;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.req = '0;
    bus.req_wr = '0;
    bus.req_phy = '0;
    bus.req_reg = '0;
    bus.req_wdata = '0;
    bus.mst_rd_data = '0;
    bus.mst_data_rdy = 1'b0;

    vt[0] = '{4'b0100, 4'b0100, {5'h00, 5'h01, 5'h00, 5'h00}, 20'h0,
              {16'h0, 16'h1140, 16'h0, 16'h0}, -1, 16'h0,
              2, 32'h5082_1140, 66, 16'h0, 1'b0};
    vt[1] = '{4'b0001, 4'b0000, {5'h00, 5'h00, 5'h00, 5'h01}, {5'h00, 5'h00, 5'h00, 5'h02},
              64'h0, 70, 16'h0141,
              0, 32'h6088_0000, 72, 16'h0141, 1'b0};
    vt[2] = '{4'b0010, 4'b0000, {5'h00, 5'h00, 5'h03, 5'h00}, {5'h00, 5'h00, 5'h01, 5'h00},
              64'h0, -1, 16'h0,
              1, 32'h6184_0000, 258, 16'hFFFF, 1'b1};
    vt[3] = '{4'b1000, 4'b0000, {5'h1F, 5'h00, 5'h00, 5'h00}, {5'h1F, 5'h00, 5'h00, 5'h00},
              64'h0, 256, 16'hBEEF,
              3, 32'h6FFC_0000, 258, 16'hBEEF, 1'b0};
    vt[4] = '{4'b1011, 4'b0001, {5'h02, 5'h00, 5'h04, 5'h1F}, {5'h03, 5'h00, 5'h05, 5'h1F},
              {16'hAAAA, 16'h0, 16'h5555, 16'hFFFF}, -1, 16'h0,
              0, 32'h5FFE_FFFF, 66, 16'h0, 1'b0};

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.ack, bus.busy, bus.mst_start, bus.err, bus.rdata, bus.mst_t_data},
        '0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_txn(vt[i].rq, vt[i].wr, vt[i].phy, vt[i].rg, vt[i].wd, vt[i].rdy_d, vt[i].rdy_dat, 0,
              vt[i].exp_g, vt[i].exp_frame, vt[i].exp_cyc, !vt[i].wr[vt[i].exp_g],
              vt[i].exp_rdata, vt[i].exp_err);
    end

    // All four requesters held: grant order and spacing of back-to-back acks
    begin
      int order[$];
      int last_ack = -1;
      int idx;
      do_reset();
      bus.req_wr = 4'hF;
      bus.req_phy = 20'($urandom);
      bus.req_reg = 20'($urandom);
      bus.req_wdata = {$urandom, $urandom};
      bus.req = 4'hF;
      for (int c = 1; c <= 5 * (WR_CYCLES + 3) + 20 && order.size() < 5; c++) begin
        @(negedge clk);
        if (bus.ack !== '0) begin
          chk("rr_onehot", $onehot(bus.ack), 1);
          idx = -1;
          for (int j = 0; j < NREQ; j++) if (bus.ack[j]) idx = j;
          order.push_back(idx);
          if (last_ack >= 0) chk("rr_gap", c - last_ack, WR_CYCLES + 3);
          last_ack = c;
        end
      end
      bus.req = '0;
      chk("rr_count", order.size(), 5);
      for (int j = 0; j < order.size(); j++) chk("rr_order", order[j], j % NREQ);
      @(negedge clk);
      chk("rr_idle", {bus.busy, bus.ack}, 5'b0);
      model_last = 0;
    end

    // Reset in the middle of a read wait
    do_reset();
    bus.req_wr = 4'b0000;
    bus.req = 4'b0010;
    for (int c = 1; c <= 32; c++) @(negedge clk);
    chk("abort_busy_before", bus.busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_state", {bus.busy, bus.mst_start, bus.ack, bus.mst_t_data}, '0);
    reset = 1'b0;
    bus.req = '0;
    @(negedge clk);
    chk("abort_no_ack", {bus.busy, bus.ack}, 5'b0);
    model_last = NREQ - 1;
    run_txn(4'b0010, 4'b0000, {5'h00, 5'h00, 5'h07, 5'h00}, {5'h00, 5'h00, 5'h09, 5'h00}, 64'h0,
            10, 16'h1234, 0, 1, model_frame(1'b0, 5'h07, 5'h09, 16'h0), model_cyc(1'b0, 10),
            1'b1, 16'h1234, 1'b0);

    // Random transactions against the model
    for (int n = 0; n < 40; n++) begin
      logic [3:0] rq, wr;
      logic [19:0] phy, rg;
      logic [63:0] wd;
      int rdy_d, drop_at, g, cyc;
      logic [15:0] dat;
      logic [31:0] fr;
      logic wbit;
      rq = 4'($urandom_range(1, 15));
      wr = 4'($urandom);
      phy = 20'($urandom);
      rg = 20'($urandom);
      wd = {$urandom, $urandom};
      rdy_d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 300));
      dat = 16'($urandom);
      drop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : 0;
      g = model_grant(rq, model_last);
      wbit = wr[g];
      fr = model_frame(wbit, phy[5*g +: 5], rg[5*g +: 5], wd[16*g +: 16]);
      cyc = model_cyc(wbit, rdy_d);
      run_txn(rq, wr, phy, rg, wd, rdy_d, dat, drop_at, g, fr, cyc, !wbit,
              (cyc == RD_TIMEOUT + 2 && !(rdy_d == RD_TIMEOUT)) ? 16'hFFFF : dat,
              (cyc == RD_TIMEOUT + 2 && !(rdy_d == RD_TIMEOUT)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
